break_value_collector: RTL and testbench

Sequential front end of the WalkSAT flip-selection path. For one unsatisfied clause, it accepts the NSAT candidate-variable valid mask, then consumes a stream of clause-occurrence records and counts, per slot, how many currently satisfied clauses would break if that slot's variable flipped. It presents the finished break values, valid mask and a frozen 32-bit random word to the combinational heuristic selector, and holds them until the flip controller acknowledges.

---
 rtl/break_value_collector.sv | 138 +++++++++++++
 tb/tb_break_value_collector.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/break_value_collector.sv
// Break-value collector for WalkSAT flip selection: gathers per-slot break counts
// for one unsatisfied clause and holds them for the heuristic selector until acknowledged.
module break_value_collector #(
  parameter int          NSAT                          = 3,
  parameter int          MAX_CLAUSES_PER_VARIABLE      = 20,
  parameter int          MAX_CLAUSES_PER_VARIABLE_BITS = 5,
  parameter logic [31:0] LFSR_SEED                     = 32'hACE12468
) (
  input  logic                                          clk_i,
  input  logic                                          rst_n_i,
  input  logic                                          start_i,
  input  logic [NSAT-1:0]                               vars_valid_i,
  input  logic                                          occ_valid_i,
  output logic                                          occ_ready_o,
  input  logic [((NSAT > 1) ? $clog2(NSAT) : 1)-1:0]    occ_slot_i,
  input  logic                                          occ_critical_i,
  input  logic                                          occ_last_i,
  output logic [NSAT*MAX_CLAUSES_PER_VARIABLE_BITS-1:0] break_values_o,
  output logic [NSAT-1:0]                               break_values_valid_o,
  output logic [31:0]                                   random_o,
  output logic                                          enable_o,
  input  logic                                          sel_ack_i,
  output logic                                          busy_o,
  output logic                                          protocol_err_o
);

  localparam int MC      = MAX_CLAUSES_PER_VARIABLE;
  localparam int MCB     = MAX_CLAUSES_PER_VARIABLE_BITS;
  localparam int SW      = (NSAT > 1) ? $clog2(NSAT) : 1;
  localparam int CW      = $clog2(MC + 1);
  localparam int SAT_INT = (MC < (1 << MCB) - 1) ? MC : (1 << MCB) - 1;
  localparam logic [MCB-1:0] SAT_V   = SAT_INT[MCB-1:0];
  localparam logic [CW-1:0]  MC_LAST = CW'(MC - 1);
  localparam logic [31:0]    LFSR_TOGGLE = 32'h80200003;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t            state_q, state_d;
  logic [NSAT-1:0]   pending_q, pending_d;
  logic [NSAT-1:0]   valid_q;
  logic [MCB-1:0]    count_q   [NSAT];
  logic [CW-1:0]     occ_cnt_q [NSAT];
  logic [31:0]       lfsr_q, lfsr_next;
  logic [31:0]       random_q;
  logic              err_q;
  logic [NSAT-1:0]   slot_hit;
  logic              rec_accept, rec_good, start_go;

  assign start_go   = (state_q == IDLE) && start_i;
  assign rec_accept = (state_q == COLLECT) && occ_valid_i;
  assign rec_good   = |(slot_hit & pending_q);
  assign lfsr_next  = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TOGGLE : 32'h0);

  // Out-of-range slot numbers decode to no hit, so they fall into the error path.
  always_comb begin
    slot_hit = '0;
    for (int k = 0; k < NSAT; k++)
      if (occ_slot_i == SW'(k)) slot_hit[k] = 1'b1;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pending_d = pending_q;
    if (start_go) begin
      pending_d = vars_valid_i;
    end else if (rec_accept && rec_good) begin
      for (int k = 0; k < NSAT; k++)
        if (slot_hit[k] && (occ_last_i || occ_cnt_q[k] == MC_LAST)) pending_d[k] = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (|vars_valid_i) ? COLLECT : DONE;
      COLLECT: if (pending_d == '0) state_d = DONE;
      DONE:    if (sel_ack_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      random_q  <= '0;
      valid_q   <= '0;
      pending_q <= '0;
      err_q     <= 1'b0;
      for (int k = 0; k < NSAT; k++) begin
        count_q[k]   <= '0;
        occ_cnt_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_next;
      pending_q <= pending_d;
      if (start_go) begin
        valid_q <= vars_valid_i;
        err_q   <= 1'b0;
        for (int k = 0; k < NSAT; k++) begin
          count_q[k]   <= '0;
          occ_cnt_q[k] <= '0;
        end
      end
      if (rec_accept) begin
        if (!rec_good) begin
          err_q <= 1'b1;
        end else begin
          for (int k = 0; k < NSAT; k++) begin
            if (slot_hit[k]) begin
              if (occ_critical_i && count_q[k] != SAT_V) count_q[k] <= count_q[k] + 1'b1;
              occ_cnt_q[k] <= occ_cnt_q[k] + 1'b1;
            end
          end
        end
      end
      // Freeze the random word on entry to DONE so the selector sees a stable value.
      if (state_q != DONE && state_d == DONE) random_q <= lfsr_q;
    end
  end

  always_comb begin
    break_values_o = '0;
    for (int k = 0; k < NSAT; k++)
      break_values_o[k*MCB +: MCB] = count_q[k];
  end

  assign break_values_valid_o = valid_q;
  assign random_o             = random_q;
  assign enable_o             = (state_q == DONE);
  assign busy_o               = (state_q != IDLE);
  assign occ_ready_o          = (state_q == COLLECT);
  assign protocol_err_o       = err_q;

endmodule

// File: tb/tb_break_value_collector.sv
// Directed bench for break_value_collector: hand-computed break values, protocol
// errors, saturation (MCB=5 and MCB=4 instances), hold/ack timing and async reset.
module tb_break_value_collector;

  localparam logic [31:0] SEED = 32'hACE12468;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  vars_valid;
  logic        occ_valid;
  logic [1:0]  occ_slot;
  logic        occ_critical;
  logic        occ_last;
  logic        sel_ack;

  logic        occ_ready, enable, busy, err;
  logic [14:0] break_values;
  logic [2:0]  bv_valid;
  logic [31:0] random;

  logic        occ_ready4, enable4, busy4, err4;
  logic [11:0] break_values4;
  logic [2:0]  bv_valid4;
  logic [31:0] random4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  break_value_collector dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .vars_valid_i(vars_valid),
    .occ_valid_i(occ_valid), .occ_ready_o(occ_ready), .occ_slot_i(occ_slot),
    .occ_critical_i(occ_critical), .occ_last_i(occ_last),
    .break_values_o(break_values), .break_values_valid_o(bv_valid),
    .random_o(random), .enable_o(enable), .sel_ack_i(sel_ack),
    .busy_o(busy), .protocol_err_o(err)
  );

  break_value_collector #(.MAX_CLAUSES_PER_VARIABLE_BITS(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .vars_valid_i(vars_valid),
    .occ_valid_i(occ_valid), .occ_ready_o(occ_ready4), .occ_slot_i(occ_slot),
    .occ_critical_i(occ_critical), .occ_last_i(occ_last),
    .break_values_o(break_values4), .break_values_valid_o(bv_valid4),
    .random_o(random4), .enable_o(enable4), .sel_ack_i(sel_ack),
    .busy_o(busy4), .protocol_err_o(err4)
  );

  // Reference Galois LFSR; m_prev is the value the DUT held at the most recent edge.
  logic [31:0] m_lfsr, m_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= SEED;
      m_prev <= '0;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= {1'b0, m_lfsr[31:1]} ^ (m_lfsr[0] ? 32'h80200003 : 32'h0);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] mask);
    start = 1'b1;
    vars_valid = mask;
    tick();
    start = 1'b0;
    vars_valid = '0;
  endtask

  task automatic send(input logic [1:0] slot, input logic crit, input logic last);
    occ_valid = 1'b1;
    occ_slot = slot;
    occ_critical = crit;
    occ_last = last;
    tick();
    occ_valid = 1'b0;
    occ_critical = 1'b0;
    occ_last = 1'b0;
  endtask

  task automatic do_ack();
    sel_ack = 1'b1;
    tick();
    sel_ack = 1'b0;
  endtask

  task automatic run_std(input string tag, output logic [31:0] rnd);
    repeat (10) tick();
    check({tag, " idle outputs"}, {enable, busy, occ_ready, err, bv_valid, break_values}, '0);
    check({tag, " idle random"}, random, 32'h0);
    do_start(3'b111);
    check({tag, " collect ready/busy"}, {occ_ready, busy, enable}, 3'b110);
    send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b0, 1'b0);
    send(2'd0, 1'b1, 1'b1);
    send(2'd1, 1'b0, 1'b1);
    send(2'd2, 1'b1, 1'b0);
    check({tag, " enable before last"}, enable, 1'b0);
    send(2'd2, 1'b1, 1'b1);
    check({tag, " enable after last"}, {enable, occ_ready}, 2'b10);
    check({tag, " break values"}, break_values, {5'd2, 5'd0, 5'd2});
    check({tag, " valid/err"}, {bv_valid, err}, {3'b111, 1'b0});
    check({tag, " random snapshot"}, random, m_prev);
    rnd = random;
    do_ack();
    check({tag, " enable after ack"}, {enable, busy}, 2'b00);
  endtask

  logic [31:0] rnd_a, rnd_b, hold_rnd;
  logic [14:0] hold_bv;

  initial begin
    rst_n = 1'b0;
    start = 1'b0; vars_valid = '0; occ_valid = 1'b0; occ_slot = '0;
    occ_critical = 1'b0; occ_last = 1'b0; sel_ack = 1'b0;
    #12 rst_n = 1'b1;

    run_std("basic", rnd_a);

    // Zero mask goes straight to DONE without ever asking for records.
    do_start(3'b000);
    check("zero enable/ready", {enable, occ_ready}, 2'b10);
    check("zero values", {bv_valid, break_values}, '0);
    do_ack();
    check("zero ack", {enable, busy}, 2'b00);

    // 20 records close slot0 at the limit; MCB=4 instance saturates at 15.
    do_start(3'b101);
    for (int i = 0; i < 20; i++) send(2'd0, 1'b1, 1'b0);
    check("sat20 still collecting", {enable, busy}, 2'b01);
    send(2'd2, 1'b0, 1'b1);
    check("sat20 done", enable, 1'b1);
    check("sat20 values", break_values, 15'd20);
    check("sat15 values mcb4", break_values4, 12'd15);
    check("sat20 err", {err, err4}, 2'b00);
    do_ack();

    // 21st record on a closed slot is dropped and flagged.
    do_start(3'b101);
    for (int i = 0; i < 20; i++) send(2'd0, 1'b1, 1'b0);
    send(2'd0, 1'b1, 1'b1);
    check("extra rec err", {err, enable}, 2'b10);
    send(2'd2, 1'b1, 1'b1);
    check("extra rec values", break_values, {5'd1, 5'd0, 5'd20});
    check("extra rec done", {enable, err}, 2'b11);
    do_ack();

    // Invalid slot and out-of-range slot are both dropped.
    do_start(3'b101);
    send(2'd1, 1'b1, 1'b1);
    check("bad slot1 err", {err, enable}, 2'b10);
    send(2'd3, 1'b1, 1'b1);
    check("bad slot3 err", {err, enable}, 2'b10);
    send(2'd0, 1'b1, 1'b1);
    send(2'd2, 1'b0, 1'b1);
    check("err done values", break_values, {5'd0, 5'd0, 5'd1});
    check("err held in done", {enable, err}, 2'b11);
    hold_rnd = random;
    hold_bv  = break_values;
    start = 1'b1; vars_valid = 3'b010;
    tick();
    start = 1'b0; vars_valid = '0;
    check("start ignored in done", {enable, bv_valid}, {1'b1, 3'b101});
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold stable", {enable, err, random, break_values}, {1'b1, 1'b1, hold_rnd, hold_bv});
    end
    do_ack();
    check("ack clears enable", {enable, err}, 2'b01);
    do_start(3'b001);
    check("start clears err", {err, bv_valid}, {1'b0, 3'b001});
    start = 1'b1; vars_valid = 3'b110;
    tick();
    start = 1'b0; vars_valid = '0;
    check("start ignored in collect", {bv_valid, occ_ready, busy}, {3'b001, 2'b11});
    send(2'd0, 1'b0, 1'b1);
    check("single slot done", {enable, break_values}, {1'b1, 15'd0});
    do_ack();

    // Asynchronous reset between edges mid-collection.
    do_start(3'b111);
    send(2'd0, 1'b1, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    check("async reset outputs", {enable, busy, occ_ready, err, bv_valid, break_values}, '0);
    check("async reset random", random, 32'h0);
    @(posedge clk);
    #7 rst_n = 1'b1;
    run_std("rerun", rnd_b);
    check("random repeatable", rnd_b, rnd_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
